// File: rtl/mips_id_pkg.sv
// mips_id_pkg
//   Shared encodings for the MIPS decode stage. Contents:
//   - primary opcodes (Instr[31:26])
//   - R-type function codes (Instr[5:0])
//   - REGIMM rt sub-codes (Instr[20:16])
//   - ALUControl codes for I-type and jump instructions, expressed as the
//     equivalent R-type funct values
//   - funct_known(): the set of R-type functions the decoder accepts
package mips_id_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_LL     = 6'h30;
    localparam logic [5:0] OP_SC     = 6'h38;

    // R-type function codes
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_MOVZ    = 6'h0A;
    localparam logic [5:0] FN_MOVN    = 6'h0B;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    // REGIMM rt sub-codes
    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    // ALUControl codes for non-R-type instructions
    localparam logic [5:0] ALU_NOP    = 6'b000000;
    localparam logic [5:0] ALU_ADD    = 6'b100000;
    localparam logic [5:0] ALU_ADDU   = 6'b100001;
    localparam logic [5:0] ALU_AND    = 6'b100100;
    localparam logic [5:0] ALU_OR     = 6'b100101;
    localparam logic [5:0] ALU_XOR    = 6'b100110;
    localparam logic [5:0] ALU_SLT    = 6'b101010;
    localparam logic [5:0] ALU_SLTU   = 6'b101011;
    localparam logic [5:0] ALU_LUI    = 6'b001111;
    localparam logic [5:0] ALU_LL     = 6'b101000;
    localparam logic [5:0] ALU_SC     = 6'b110110;
    localparam logic [5:0] ALU_BEQ    = 6'b000100;
    localparam logic [5:0] ALU_BNE    = 6'b000101;
    localparam logic [5:0] ALU_BLEZ   = 6'b000110;
    localparam logic [5:0] ALU_BGTZ   = 6'b000111;
    localparam logic [5:0] ALU_REGIMM = 6'b000001;
    localparam logic [5:0] ALU_J      = 6'b000010;

    function automatic logic funct_known(input logic [5:0] f);
        case (f)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_JR, FN_JALR, FN_MOVZ, FN_MOVN, FN_SYSCALL,
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_id_regfile.sv
// mips_id_regfile
//   32 x 32-bit architectural register file with three combinational read
//   ports and one synchronous write port. Register 0 is hard-wired to zero.
//   The whole array clears asynchronously while RESET is low.
//   Build option MIPS_RF_WRITE_THROUGH_EN: a read port whose address matches
//   a pending nonzero write returns the write data in the same cycle.
// Ports
//   CLK        in   1   write clock (posedge)
//   RESET      in   1   asynchronous active-low clear
//   i_raddr_a  in   5   read address A      o_rdata_a out 32
//   i_raddr_b  in   5   read address B      o_rdata_b out 32
//   i_raddr_c  in   5   read address C      o_rdata_c out 32
//   i_waddr    in   5   write address
//   i_wdata    in   32  write data
//   i_we       in   1   write enable
module mips_id_regfile
    import mips_id_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    input  logic [4:0]  i_raddr_c,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b,
    output logic [31:0] o_rdata_c
);

    logic [31:0] r_regs [0:31];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    function automatic logic [31:0] rd(input logic [4:0] a);
        if (a == 5'd0) begin
            return '0;
        end
`ifdef MIPS_RF_WRITE_THROUGH_EN
        if (i_we && (a == i_waddr)) begin
            return i_wdata;
        end
`endif
        return r_regs[a];
    endfunction

    assign o_rdata_a = rd(i_raddr_a);
    assign o_rdata_b = rd(i_raddr_b);
    assign o_rdata_c = rd(i_raddr_c);

endmodule

// File: rtl/mips_id_core.sv
// mips_id_core
//   Decode-stage core of a 5-stage MIPS pipeline: register file, instruction
//   decoder (control flags + 6-bit ALU code) and branch/jump target adder.
//   Everything is combinational except register-file writes. Reset clears
//   the register file only; decode outputs do not depend on it.
//   Build option MIPS_RF_WRITE_THROUGH_EN enables same-cycle write bypass
//   on all three read ports (see mips_id_regfile).
// Ports
//   CLK, RESET (async active-low)
//   Instr, Instr_PC_Plus4, RegisterValue (JR/JALR target), RegC (3rd read addr)
//   WriteReg, WriteData, Write          writeback port
//   DataA/DataB/DataC                   reads of rs, rt, RegC
//   Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite,
//   JumpRegister, SignOrZero, Syscall   decode flags
//   ALUControl                          6-bit ALU operation
//   NextInstructionAddress              branch/jump target
module mips_id_core
    import mips_id_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr,
    input  logic [31:0] Instr_PC_Plus4,
    input  logic [31:0] RegisterValue,
    input  logic [4:0]  RegC,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteData,
    input  logic        Write,
    output logic [31:0] DataA,
    output logic [31:0] DataB,
    output logic [31:0] DataC,
    output logic        Link,
    output logic        RegDest,
    output logic        Jump,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        JumpRegister,
    output logic        SignOrZero,
    output logic        Syscall,
    output logic [5:0]  ALUControl,
    output logic [31:0] NextInstructionAddress
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [31:0] w_branch_off;
    logic [31:0] w_jump_tgt;

    assign w_op    = Instr[31:26];
    assign w_rs    = Instr[25:21];
    assign w_rt    = Instr[20:16];
    assign w_funct = Instr[5:0];

    mips_id_regfile u_regfile (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .i_raddr_c (RegC),
        .i_waddr   (WriteReg),
        .i_wdata   (WriteData),
        .i_we      (Write),
        .o_rdata_a (DataA),
        .o_rdata_b (DataB),
        .o_rdata_c (DataC)
    );

    always_comb begin
        Link         = 1'b0;
        RegDest      = 1'b0;
        Jump         = 1'b0;
        Branch       = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        ALUSrc       = 1'b0;
        RegWrite     = 1'b0;
        JumpRegister = 1'b0;
        SignOrZero   = 1'b0;
        Syscall      = 1'b0;
        ALUControl   = ALU_NOP;

        case (w_op)
            OP_RTYPE: begin
                if (funct_known(w_funct)) begin
                    RegDest    = 1'b1;
                    SignOrZero = 1'b1;
                    ALUControl = w_funct;
                    RegWrite   = (w_funct != FN_JR) && (w_funct != FN_SYSCALL);
                    if ((w_funct == FN_JR) || (w_funct == FN_JALR)) begin
                        Jump         = 1'b1;
                        JumpRegister = 1'b1;
                    end
                    Link    = (w_funct == FN_JALR);
                    Syscall = (w_funct == FN_SYSCALL);
                end
            end
            OP_REGIMM: begin
                case (w_rt)
                    RT_BLTZ, RT_BGEZ: begin
                        Branch     = 1'b1;
                        SignOrZero = 1'b1;
                        ALUControl = ALU_REGIMM;
                    end
                    // Linking branches compute the return address through the ALU
                    RT_BLTZAL, RT_BGEZAL: begin
                        Branch     = 1'b1;
                        Link       = 1'b1;
                        RegWrite   = 1'b1;
                        SignOrZero = 1'b1;
                        ALUControl = ALU_ADDU;
                    end
                    default: ;
                endcase
            end
            OP_J: begin
                Jump       = 1'b1;
                SignOrZero = 1'b1;
                ALUControl = ALU_J;
            end
            OP_JAL: begin
                Jump       = 1'b1;
                Link       = 1'b1;
                RegWrite   = 1'b1;
                SignOrZero = 1'b1;
                ALUControl = ALU_ADDU;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                Branch     = 1'b1;
                SignOrZero = 1'b1;
                case (w_op)
                    OP_BEQ:  ALUControl = ALU_BEQ;
                    OP_BNE:  ALUControl = ALU_BNE;
                    OP_BLEZ: ALUControl = ALU_BLEZ;
                    default: ALUControl = ALU_BGTZ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LUI: begin
                ALUSrc     = 1'b1;
                RegWrite   = 1'b1;
                SignOrZero = 1'b1;
                case (w_op)
                    OP_ADDI:  ALUControl = ALU_ADD;
                    OP_ADDIU: ALUControl = ALU_ADDU;
                    OP_SLTI:  ALUControl = ALU_SLT;
                    OP_SLTIU: ALUControl = ALU_SLTU;
                    default:  ALUControl = ALU_LUI;
                endcase
            end
            // Logical immediates zero-extend
            OP_ANDI, OP_ORI, OP_XORI: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
                case (w_op)
                    OP_ANDI: ALUControl = ALU_AND;
                    OP_ORI:  ALUControl = ALU_OR;
                    default: ALUControl = ALU_XOR;
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                MemRead    = 1'b1;
                ALUSrc     = 1'b1;
                RegWrite   = 1'b1;
                SignOrZero = 1'b1;
                ALUControl = ALU_ADDU;
            end
            OP_SB, OP_SH, OP_SW: begin
                MemWrite   = 1'b1;
                ALUSrc     = 1'b1;
                SignOrZero = 1'b1;
                ALUControl = ALU_ADDU;
            end
            // LL/SC raise Syscall so the wrapper flushes the pipeline around them
            OP_LL: begin
                MemRead    = 1'b1;
                ALUSrc     = 1'b1;
                RegWrite   = 1'b1;
                SignOrZero = 1'b1;
                Syscall    = 1'b1;
                ALUControl = ALU_LL;
            end
            OP_SC: begin
                MemWrite   = 1'b1;
                ALUSrc     = 1'b1;
                RegWrite   = 1'b1;
                SignOrZero = 1'b1;
                Syscall    = 1'b1;
                ALUControl = ALU_SC;
            end
            default: ;
        endcase
    end

    assign w_branch_off = {{14{Instr[15]}}, Instr[15:0], 2'b00};
    assign w_jump_tgt   = {Instr_PC_Plus4[31:28], Instr[25:0], 2'b00};

    always_comb begin
        if (Jump && JumpRegister) begin
            NextInstructionAddress = RegisterValue;
        end else if (Jump) begin
            NextInstructionAddress = w_jump_tgt;
        end else begin
            NextInstructionAddress = Instr_PC_Plus4 + w_branch_off;
        end
    end

endmodule

// File: tb/tb_mips_id_core.sv
// tb_mips_id_core
//   Bench for mips_id_core. Register-file reads are checked against a
//   bench-side shadow array through a scoreboard queue; decode is checked
//   from a table of hand-computed vectors.
module tb_mips_id_core;

    logic        CLK;
    logic        RESET;
    logic [31:0] Instr;
    logic [31:0] Instr_PC_Plus4;
    logic [31:0] RegisterValue;
    logic [4:0]  RegC;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        Write;
    logic [31:0] DataA, DataB, DataC;
    logic        Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc;
    logic        RegWrite, JumpRegister, SignOrZero, Syscall;
    logic [5:0]  ALUControl;
    logic [31:0] NextInstructionAddress;

    mips_id_core dut (
        .CLK                    (CLK),
        .RESET                  (RESET),
        .Instr                  (Instr),
        .Instr_PC_Plus4         (Instr_PC_Plus4),
        .RegisterValue          (RegisterValue),
        .RegC                   (RegC),
        .WriteReg               (WriteReg),
        .WriteData              (WriteData),
        .Write                  (Write),
        .DataA                  (DataA),
        .DataB                  (DataB),
        .DataC                  (DataC),
        .Link                   (Link),
        .RegDest                (RegDest),
        .Jump                   (Jump),
        .Branch                 (Branch),
        .MemRead                (MemRead),
        .MemWrite               (MemWrite),
        .ALUSrc                 (ALUSrc),
        .RegWrite               (RegWrite),
        .JumpRegister           (JumpRegister),
        .SignOrZero             (SignOrZero),
        .Syscall                (Syscall),
        .ALUControl             (ALUControl),
        .NextInstructionAddress (NextInstructionAddress)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {Link,RegDest,Jump,Branch,MemRead,MemWrite,ALUSrc,RegWrite,JumpRegister,SignOrZero,Syscall}
    logic [10:0] w_flags;
    assign w_flags = {Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc,
                      RegWrite, JumpRegister, SignOrZero, Syscall};

    typedef struct {
        logic [31:0] instr;
        logic [10:0] flags;
        logic [5:0]  alu;
        logic [31:0] target;
    } vec_t;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } rd_exp_t;

    vec_t        vecs [18];
    vec_t        q_dec [$];
    rd_exp_t     q_rd  [$];
    logic [31:0] model [32];
    int          n_checks;
    int          n_errors;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void expect_rd(input int sel, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        q_rd.push_back(e);
    endfunction

    function automatic void drain_rd();
        rd_exp_t e;
        logic [31:0] act;
        while (q_rd.size() > 0) begin
            e = q_rd.pop_front();
            case (e.sel)
                0:       act = DataA;
                1:       act = DataB;
                default: act = DataC;
            endcase
            check(e.name, act, e.exp);
        end
    endfunction

    function automatic logic [31:0] rd_instr(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, 16'h0000};
    endfunction

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge CLK);
        WriteReg  = a;
        WriteData = d;
        Write     = 1'b1;
        @(negedge CLK);
        Write     = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        vecs[0]  = '{32'h00A62020, 11'b01000001010, 6'b100000, 32'h00408090}; // add
        vecs[1]  = '{32'h8C220004, 11'b00001011010, 6'b100001, 32'h00400020}; // lw
        vecs[2]  = '{32'h1000FFFF, 11'b00010000010, 6'b000100, 32'h0040000C}; // beq -1
        vecs[3]  = '{32'h0C100000, 11'b10100001010, 6'b100001, 32'h00400000}; // jal
        vecs[4]  = '{32'h03E00008, 11'b01100000110, 6'b001000, 32'h12345678}; // jr r31
        vecs[5]  = '{32'h0000000C, 11'b01000000011, 6'b001100, 32'h00400040}; // syscall
        vecs[6]  = '{32'h30A5FFFF, 11'b00000011000, 6'b100100, 32'h0040000C}; // andi
        vecs[7]  = '{32'h3C011234, 11'b00000011010, 6'b001111, 32'h004048E0}; // lui
        vecs[8]  = '{32'hAC220008, 11'b00000110010, 6'b100001, 32'h00400030}; // sw
        vecs[9]  = '{32'h04118000, 11'b10010001010, 6'b100001, 32'h003E0010}; // bgezal, wraps
        vecs[10] = '{32'h08000004, 11'b00100000010, 6'b000010, 32'h00000010}; // j
        vecs[11] = '{32'h03E0F809, 11'b11100001110, 6'b001001, 32'h12345678}; // jalr
        vecs[12] = '{32'hC0220000, 11'b00001011011, 6'b101000, 32'h00400010}; // ll
        vecs[13] = '{32'hE0220000, 11'b00000111011, 6'b110110, 32'h00400010}; // sc
        vecs[14] = '{32'hFC000000, 11'b00000000000, 6'b000000, 32'h00400010}; // unknown op
        vecs[15] = '{32'h00000001, 11'b00000000000, 6'b000000, 32'h00400014}; // unknown funct
        vecs[16] = '{32'h04000001, 11'b00010000010, 6'b000001, 32'h00400014}; // bltz
        vecs[17] = '{32'h34A50001, 11'b00000011000, 6'b100101, 32'h00400014}; // ori

        RESET          = 1'b0;
        Instr          = rd_instr(5'd5, 5'd6);
        Instr_PC_Plus4 = 32'h00400010;
        RegisterValue  = 32'h12345678;
        RegC           = 5'd7;
        WriteReg       = 5'd0;
        WriteData      = '0;
        Write          = 1'b0;

        repeat (2) @(negedge CLK);
        expect_rd(0, 32'h0, "reset_dataA");
        expect_rd(1, 32'h0, "reset_dataB");
        expect_rd(2, 32'h0, "reset_dataC");
        #2 drain_rd();
        RESET = 1'b1;

        do_write(5'd5, 32'hDEADBEEF);
        Instr = rd_instr(5'd5, 5'd0);
        expect_rd(0, model[5], "r5_read");
        expect_rd(1, 32'h0, "r0_read_b");
        #2 drain_rd();

        do_write(5'd0, 32'h00000001);
        Instr = rd_instr(5'd0, 5'd5);
        expect_rd(0, 32'h0, "r0_write_ignored");
        expect_rd(1, 32'hDEADBEEF, "r5_read_b");
        #2 drain_rd();

        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), (32'(i) * 32'h01010101) ^ 32'hC0DE0000);
        end
        for (int i = 0; i < 32; i++) begin
            RegC  = 5'(i);
            Instr = rd_instr(5'(31 - i), 5'(i));
            expect_rd(2, model[i], "portC_sweep");
            expect_rd(1, model[i], "portB_sweep");
            expect_rd(0, model[31 - i], "portA_sweep");
            #1 drain_rd();
        end

        // Same-cycle write and read of r9
        @(negedge CLK);
        Instr     = rd_instr(5'd0, 5'd9);
        RegC      = 5'd9;
        WriteReg  = 5'd9;
        WriteData = 32'h0BADF00D;
        Write     = 1'b1;
`ifdef MIPS_RF_WRITE_THROUGH_EN
        expect_rd(1, 32'h0BADF00D, "same_cycle_b");
        expect_rd(2, 32'h0BADF00D, "same_cycle_c");
`else
        expect_rd(1, model[9], "same_cycle_b");
        expect_rd(2, model[9], "same_cycle_c");
`endif
        expect_rd(0, 32'h0, "same_cycle_r0");
        #2 drain_rd();
        @(negedge CLK);
        model[9] = 32'h0BADF00D;
        // Pending write to r0 must never be visible
        WriteReg  = 5'd0;
        WriteData = 32'hFFFFFFFF;
        Instr     = rd_instr(5'd0, 5'd9);
        expect_rd(0, 32'h0, "r0_pending_write");
        expect_rd(1, model[9], "r9_after_write");
        #2 drain_rd();
        @(negedge CLK);
        Write = 1'b0;

        // Reset mid-run: array clears, decode unaffected
        @(negedge CLK);
        Instr = 32'h00A62020;
        RegC  = 5'd31;
        #1 RESET = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        expect_rd(0, 32'h0, "midreset_r5");
        expect_rd(1, 32'h0, "midreset_r6");
        expect_rd(2, 32'h0, "midreset_r31");
        #1 drain_rd();
        check("midreset_flags", 32'(w_flags), 32'(vecs[0].flags));
        check("midreset_alu", 32'(ALUControl), 32'(vecs[0].alu));
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        Instr = rd_instr(5'd5, 5'd9);
        expect_rd(0, 32'h0, "postreset_r5");
        expect_rd(1, 32'h0, "postreset_r9");
        #2 drain_rd();

        // Decode table
        Instr_PC_Plus4 = 32'h00400010;
        RegisterValue  = 32'h12345678;
        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            Instr = vecs[i].instr;
            q_dec.push_back(vecs[i]);
            #2;
            v = q_dec.pop_front();
            check($sformatf("flags[%0d]", i), 32'(w_flags), 32'(v.flags));
            check($sformatf("alu[%0d]", i), 32'(ALUControl), 32'(v.alu));
            check($sformatf("target[%0d]", i), NextInstructionAddress, v.target);
        end

        // Jump region comes from PC+4 upper bits
        @(negedge CLK);
        Instr_PC_Plus4 = 32'hA0000008;
        Instr          = 32'h0BFFFFFF;
        #2 check("j_region", NextInstructionAddress, 32'hAFFFFFFC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
